// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - time-multiplexed N-digit 7-segment scanner with frame-aligned loads
module varredura_display #(
  parameter int NUM_DIGITOS = 4,
  parameter int DIV_REFRESH = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [4*NUM_DIGITOS-1:0]   valor,
  input  logic                       carregar,
  input  logic                       habilitar,
  input  logic                       apagar_zeros,
  output logic [3:0]                 digito,
  output logic [NUM_DIGITOS-1:0]     anodo,
  output logic                       pendente
);

  localparam int CW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
  localparam int IW = $clog2(NUM_DIGITOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DIV_REFRESH - 1);
  localparam logic [IW-1:0] IND_MAX  = IW'(NUM_DIGITOS - 1);

  logic [CW-1:0]              r_cont;
  logic [IW-1:0]              r_indice;
  logic [4*NUM_DIGITOS-1:0]   r_exib;
  logic [4*NUM_DIGITOS-1:0]   r_espera;
  logic                       r_pendente;
  logic [3:0]                 r_digito;
  logic [NUM_DIGITOS-1:0]     r_anodo;

  logic                       w_tick;
  logic                       w_fronteira;
  logic                       w_apaga;
  logic [3:0]                 w_nibble;
  logic [NUM_DIGITOS-1:0]     w_anodo;

  assign w_tick      = habilitar && (r_cont == CONT_MAX);
  assign w_fronteira = w_tick && (r_indice == IND_MAX);

  // A slot is blank only if it and every more-significant nibble are zero.
  always_comb begin
    w_nibble = 4'h0;
    w_apaga  = apagar_zeros && (r_indice != '0);
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (IW'(i) == r_indice)
        w_nibble = r_exib[4*i +: 4];
      if ((IW'(i) >= r_indice) && (r_exib[4*i +: 4] != 4'h0))
        w_apaga = 1'b0;
    end
    if (!habilitar || w_apaga)
      w_anodo = '1;
    else
      w_anodo = ~({{(NUM_DIGITOS-1){1'b0}}, 1'b1} << r_indice);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont   <= '0;
      r_indice <= '0;
    end else if (w_tick) begin
      r_cont   <= '0;
      r_indice <= (r_indice == IND_MAX) ? '0 : r_indice + 1'b1;
    end else if (habilitar) begin
      r_cont   <= r_cont + 1'b1;
    end
  end

  // A load landing on the boundary bypasses espera and wins over any older pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exib     <= '0;
      r_espera   <= '0;
      r_pendente <= 1'b0;
    end else if (w_fronteira) begin
      if (carregar)
        r_exib <= valor;
      else if (r_pendente)
        r_exib <= r_espera;
      r_pendente <= 1'b0;
    end else if (carregar) begin
      r_espera   <= valor;
      r_pendente <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digito <= 4'h0;
      r_anodo  <= '1;
    end else begin
      r_digito <= w_nibble;
      r_anodo  <= w_anodo;
    end
  end

  assign digito   = r_digito;
  assign anodo    = r_anodo;
  assign pendente = r_pendente;

endmodule

// File: doc/varredura_display.md
# varredura_display

Time-multiplexed scanner for an N-digit common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder (`Decodificador7Seg`): each scan slot it presents one 4-bit nibble on `digito`, which feeds the decoder's `entrada`, and it drives the active-low digit enables. New values are captured from the core through a load strobe and applied only at frame boundaries, so a frame never shows digits from two different values. Optional leading-zero blanking is included.

## Interface
- `NUM_DIGITOS`, default 4: number of display digits, N ≥ 2.
- `DIV_REFRESH`, default 50000: clock cycles each digit stays active, ≥ 1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `valor` input 4*N: value to display; nibble i drives digit i; digit 0 is the rightmost (LS) digit.
- `carregar` input 1: one-cycle load strobe; samples `valor`.
- `habilitar` input 1: scan enable.
- `apagar_zeros` input 1: leading-zero blanking enable.
- `digito` output 4: nibble for the decoder.
- `anodo` output N: digit enables, active-low, one-hot-low when lit.
- `pendente` output 1: a loaded value is waiting for the frame boundary.

## Operation
- **Registers:**
  - `cont`: refresh counter, 0..DIV_REFRESH-1.
  - `indice`: scan index, 0..N-1.
  - `exib`: displayed value, 4*N bits.
  - `espera`: holding value, 4*N bits.
  - `pendente` flag.
- **Tick:** `tick` = `habilitar` && (`cont` == DIV_REFRESH-1).
  - On `tick`: `cont` ← 0 and `indice` ← (`indice`+1) mod N.
  - Otherwise, when `habilitar`=1: `cont` ← `cont`+1.
- **Frame boundary:** `tick` while `indice` == N-1 (wrap to 0).
  - At the boundary, if `pendente`=1: `exib` ← `espera` and `pendente` ← 0.
- **Load:**
  - `carregar`=1 with no boundary in the same cycle: `espera` ← `valor` and `pendente` ← 1.
  - A repeated `carregar` while pending overwrites `espera`; last load wins.
  - `carregar` on the boundary cycle: `exib` ← `valor` directly, and `pendente` ← 0. The new value takes precedence over any older `espera`.
- **Blanking:** a slot is blanked when `apagar_zeros`=1, `indice` > 0, and `exib` nibbles `indice`..N-1 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- **Registered outputs, per cycle:**
  - `habilitar`=0 or slot blanked: `anodo` ← all ones.
  - Otherwise: `anodo` ← ~(1 << `indice`).
  - `digito` ← `exib`[4*`indice` +: 4] in every case, including blanked slots.
- **Disable (`habilitar`=0):**
  - `cont` and `indice` freeze.
  - No boundary transfers occur.
  - `carregar` is still accepted into `espera`.

## Timing
- **Reset values:**
  - `cont`=0, `indice`=0.
  - `exib`=0, `espera`=0.
  - `pendente`=0.
  - `digito`=4'h0, `anodo`=all ones.
- **Asynchronous reset:** assertion mid-frame forces these values immediately, without waiting for a clock edge. The first rising edge after release with `habilitar`=1 lights digit 0.
- **Output latency:** `digito`/`anodo` follow `indice`/`exib` by one cycle; there is no combinational path from inputs to outputs.
- **Slot length:** each digit is lit for exactly DIV_REFRESH cycles; a frame is N*DIV_REFRESH cycles.
- **Load-to-display latency:** at most one frame plus one cycle. `pendente` rises the cycle after `carregar` and falls on the boundary edge.
- **Re-enable:** after disable, scanning resumes at the same `indice`, with the remaining count of the interrupted slot.
- **Anode guard:** exactly one `anodo` bit is low at any time, or none.

## Test plan
All scenarios use N=4 and DIV_REFRESH=4.
1. **Reset:** assert `rst_n`=0 mid-scan, async to `clk` → `anodo`=4'b1111, `digito`=0, `pendente`=0 immediately; after release with `habilitar`=1, digit 0 is lit on the next edge.
2. **Normal scan:** `valor`=16'h1A3F with a `carregar` pulse → `pendente`=1 until the boundary. The next frame shows `digito` F,3,A,1 with `anodo` 1110,1101,1011,0111, each held 4 cycles; `pendente` returns to 0.
3. **Blanking:** `apagar_zeros`=1.
   - 16'h0005 → slots 1-3 give `anodo`=1111; slot 0 gives 1110 with `digito`=5.
   - 16'h0000 → only digit 0 is lit, showing 0.
   - 16'h0100 → digits 2,1,0 are lit.
4. **Last load wins:** `carregar` 16'h1111 then 16'h2222 within one frame → the next frame shows only 2s; no frame contains mixed 1s and 2s.
5. **Load on boundary:** `carregar` exactly on the wrap cycle with an older value pending → the new value is displayed from the next frame and `pendente`=0.
6. **Disable mid-slot:** drop `habilitar` 2 cycles into slot 2 → `anodo`=1111 and `cont` frozen. On re-enable, slot 2 lasts 2 more cycles, then slot 3.
